// File: rtl/add_share_sequencer.sv
// add_share_sequencer: two requesters share one external 4-bit adder.
// A W-bit add (W = 4*NIBBLES) is sequenced one nibble per cycle.
// The carry ripples between nibbles through a local register.
// Requesters are served round-robin.
// The W+1-bit result is held until the consumer takes it.
module add_share_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  output logic [3:0]           adder_a,
  output logic [3:0]           adder_b,
  input  logic [4:0]           adder_s,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [4*NIBBLES:0]   res_sum
);

  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST_STEP = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_msb;
  logic         r_carry;
  logic         r_id;
  logic         r_last_grant;
  logic [3:0]   r_step;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  logic         w_last_step;
  logic [3:0]   w_nib_a;
  logic [3:0]   w_nib_b;
  logic [4:0]   w_t;

  // Round-robin choice: on a tie, the requester not granted last time wins.
  // Both grants are held low while reset is asserted.
  always_comb begin
    w_grant0 = !rst && req0_valid && (!req1_valid || r_last_grant);
    w_grant1 = !rst && req1_valid && (!req0_valid || !r_last_grant);
  end

  // Select the operand nibbles addressed by the current step.
  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_step == 4'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  // The external adder has no carry-in.
  // The rippled carry is added to its 5-bit sum here; the total is at most 31.
  assign w_t         = adder_s + {4'b0000, r_carry};
  assign w_last_step = (r_step == LAST_STEP);
  assign res_id      = r_id;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, handshakes and adder drive; outputs are 0 unless the state asserts them.
  always_comb begin
    w_state_next = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    adder_a      = 4'h0;
    adder_b      = 4'h0;
    res_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_grant0 || w_grant1) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        adder_a = w_nib_a;
        adder_b = w_nib_b;
        if (w_last_step) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Capture the granted requester's operands and identity on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_a          <= w_grant1 ? req1_a : req0_a;
      r_b          <= w_grant1 ? req1_b : req0_b;
      r_id         <= w_grant1;
      r_last_grant <= w_grant1;
    end
  end

  // Step counter and carry chain.
  // The final carry becomes the result MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step  <= 4'h0;
      r_carry <= 1'b0;
      r_msb   <= 1'b0;
    end else if (w_accept) begin
      r_step  <= 4'h0;
      r_carry <= 1'b0;
    end else if (r_state == RUN) begin
      r_carry <= w_t[4];
      if (w_last_step) begin
        r_msb <= w_t[4];
      end else begin
        r_step <= r_step + 4'h1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_sum
      logic [3:0] r_nib;

      // Each result nibble is written only during its own step.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_nib <= 4'h0;
        end else if (r_state == RUN && r_step == 4'(gi)) begin
          r_nib <= w_t[3:0];
        end
      end

      assign res_sum[4*gi +: 4] = r_nib;
    end
  endgenerate

  assign res_sum[W] = r_msb;

endmodule

// File: tb/tb_add_share_sequencer.sv
// Bench for add_share_sequencer.
// Directed cases run on a 4-nibble instance.
// Random traffic runs on 4-, 1- and 8-nibble instances against an arbitration/latency/sum model.
module tb_add_share_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed instance (NIBBLES = 4) ----------------
  logic        d_rst, d_v0, d_v1, d_r0, d_r1, d_rv, d_rr, d_rid;
  logic [15:0] d_a0, d_b0, d_a1, d_b1;
  logic [3:0]  d_aa, d_ab;
  logic [4:0]  d_as;
  logic [16:0] d_sum;

  assign d_as = {1'b0, d_aa} + {1'b0, d_ab};

  add_share_sequencer #(.NIBBLES(4)) u_dut (
    .clk(clk), .rst(d_rst),
    .req0_valid(d_v0), .req0_ready(d_r0), .req0_a(d_a0), .req0_b(d_b0),
    .req1_valid(d_v1), .req1_ready(d_r1), .req1_a(d_a1), .req1_b(d_b1),
    .adder_a(d_aa), .adder_b(d_ab), .adder_s(d_as),
    .res_valid(d_rv), .res_ready(d_rr), .res_id(d_rid), .res_sum(d_sum)
  );

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_req0_ready"}, d_r0, 0);
    check_val({pfx, "_req1_ready"}, d_r1, 0);
    check_val({pfx, "_res_valid"}, d_rv, 0);
    check_val({pfx, "_res_id"}, d_rid, 0);
    check_val({pfx, "_res_sum"}, d_sum, 0);
    check_val({pfx, "_adder_a"}, d_aa, 0);
    check_val({pfx, "_adder_b"}, d_ab, 0);
  endtask

  // One operation from requester id.
  // stall > 0 holds res_ready low for that many cycles in DONE.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b, input int stall);
    int          lat;
    logic [16:0] exp_sum;
    exp_sum = {1'b0, a} + {1'b0, b};
    @(negedge clk);
    if (id) begin d_v1 = 1'b1; d_a1 = a; d_b1 = b; end
    else    begin d_v0 = 1'b1; d_a0 = a; d_b0 = b; end
    d_rr = (stall == 0);
    #2;
    check_val("acc_ready", id ? d_r1 : d_r0, 1);
    check_val("acc_other", id ? d_r0 : d_r1, 0);
    @(negedge clk);
    if (id) d_v1 = 1'b0; else d_v0 = 1'b0;
    if (stall > 0) begin
      if (id) d_v0 = 1'b1; else d_v1 = 1'b1;
    end
    #2;
    check_val("ready_one_cycle", id ? d_r1 : d_r0, 0);
    lat = 0;
    while (!d_rv && lat < 20) begin
      @(negedge clk); #2; lat++;
    end
    check_val("latency", lat, 4);
    check_val("sum", d_sum, exp_sum);
    check_val("id", d_rid, id);
    $display("op id=%0d a=0x%04h b=0x%04h sum=0x%05h lat=%0d stall=%0d", id, a, b, d_sum, lat, stall);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk); #2;
        check_val("stall_valid", d_rv, 1);
        check_val("stall_sum", d_sum, exp_sum);
        check_val("stall_ready0", d_r0, 0);
        check_val("stall_ready1", d_r1, 0);
        check_val("stall_adder_a", d_aa, 0);
      end
      @(negedge clk);
      d_rr = 1'b1; d_v0 = 1'b0; d_v1 = 1'b0;
      #2;
      check_val("release_valid", d_rv, 1);
    end
    @(negedge clk); #2;
    check_val("completion", d_rv, 0);
  endtask

  initial begin
    int got;
    d_rst = 1'b1; d_v0 = 1'b1; d_v1 = 1'b1; d_rr = 1'b1;
    d_a0 = 16'h0; d_b0 = 16'h0; d_a1 = 16'h0; d_b1 = 16'h0;
    repeat (2) @(negedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    d_rst = 1'b0; d_v0 = 1'b0; d_v1 = 1'b0;

    // Basic add, ripple cases, back-pressure.
    do_op(1'b0, 16'h0002, 16'h0001, 0);
    do_op(1'b1, 16'hFFFF, 16'h0001, 0);
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 0);
    do_op(1'b0, 16'h1357, 16'h2468, 10);

    // Reset during step 2 of an operation from requester 1.
    @(negedge clk);
    d_v1 = 1'b1; d_a1 = 16'h0321; d_b1 = 16'h0456;
    #2;
    check_val("mid_acc_ready", d_r1, 1);
    @(negedge clk);
    d_v1 = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_val("step2_adder_a", d_aa, 4'h3);
    check_val("step2_adder_b", d_ab, 4'h4);
    d_rst = 1'b1;
    #1;
    check_outputs_zero("midrun");
    @(negedge clk);
    d_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      check_val("no_result", d_rv, 0);
    end
    do_op(1'b0, 16'h1234, 16'h4321, 0);

    // Round-robin from a fresh reset with both requesters always valid.
    @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    d_v0 = 1'b1; d_a0 = 16'd7; d_b0 = 16'd9;
    d_v1 = 1'b1; d_a1 = 16'd3; d_b1 = 16'd4;
    d_rr = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      #2;
      check_val("rr_onehot", d_r0 & d_r1, 0);
      if (d_rv && d_rr) begin
        check_val("rr_id", d_rid, got % 2);
        check_val("rr_sum", d_sum, (got % 2) ? 17'h00007 : 17'h00010);
        $display("rr result %0d id=%0d sum=0x%05h", got, d_rid, d_sum);
        got++;
      end
      @(negedge clk);
    end
    check_val("rr_count", got, 4);
    d_v0 = 1'b0; d_v1 = 1'b0;
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    n_done++;
  end

  // ---------------- randomized instances ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rand
      localparam int NB = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);
      localparam int WW = 4 * NB;

      logic          rst, v0, v1, r0, r1, rv, rr, rid;
      logic [WW-1:0] a0, b0, a1, b1;
      logic [3:0]    aa, ab;
      logic [4:0]    as_s;
      logic [WW:0]   sum;

      assign as_s = {1'b0, aa} + {1'b0, ab};

      add_share_sequencer #(.NIBBLES(NB)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
        .adder_a(aa), .adder_b(ab), .adder_s(as_s),
        .res_valid(rv), .res_ready(rr), .res_id(rid), .res_sum(sum)
      );

      initial begin
        logic        busy, last, e0, e1, acc0, acc1, exp_valid, exp_id;
        logic [WW:0] exp_sum;
        int          cyc, acc_cyc, nops;
        busy = 1'b0; last = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
        exp_id = 1'b0; exp_sum = '0;
        cyc = 0; acc_cyc = 0; nops = 0;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          cyc++;
          // Operands change only when not pending.
          if (acc0 || !v0) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = ($urandom_range(0, 4) == 0) ? '1 : WW'($urandom);
            b0 = WW'($urandom);
          end
          if (acc1 || !v1) begin
            v1 = ($urandom_range(0, 3) != 0);
            a1 = WW'($urandom);
            b1 = ($urandom_range(0, 4) == 0) ? '1 : WW'($urandom);
          end
          rr = ($urandom_range(0, 3) != 0);
          #2;
          // Arbitration: only when idle; ties go to the requester not served last.
          e0 = !busy && v0 && (!v1 || last);
          e1 = !busy && v1 && (!v0 || !last);
          check_val($sformatf("n%0d_ready0", NB), r0, e0);
          check_val($sformatf("n%0d_ready1", NB), r1, e1);
          // Result appears NB cycles after the accept edge and stays until taken.
          exp_valid = busy && (cyc - acc_cyc >= NB + 1);
          check_val($sformatf("n%0d_res_valid", NB), rv, exp_valid);
          if (exp_valid) begin
            check_val($sformatf("n%0d_res_sum", NB), sum, exp_sum);
            check_val($sformatf("n%0d_res_id", NB), rid, exp_id);
            if (rr) begin
              $display("n%0d result id=%0d sum=0x%0h", NB, rid, sum);
              busy = 1'b0;
              nops++;
            end
          end
          acc0 = e0;
          acc1 = e1;
          if (e0 || e1) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            exp_id  = e1;
            exp_sum = e1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            last    = e1;
          end
        end
        check_val($sformatf("n%0d_ops_completed", NB), nops > 10, 1);
        n_done++;
      end
    end
  endgenerate

  initial begin
    for (int i = 0; i < 20000 && n_done < 4; i++) begin
      @(negedge clk);
    end
    check_val("all_done", n_done, 4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
